// File: rtl/clock_pkg.sv
// clock_pkg: shared alarm FSM states, field widths and time limits
package clock_pkg;
    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZE   = 2'd3
    } state_t;
    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int CNT_W  = 10;
    localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
endpackage

// File: rtl/alarm_sec_counter.sv
// alarm_sec_counter: sec_tick counter with clear and done-at-limit strobe
module alarm_sec_counter
    import clock_pkg::*;
(
    input  logic             MCLK,
    input  logic             RESET,
    input  logic             clr,
    input  logic             en,
    input  logic             sec_tick,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);
    logic [CNT_W-1:0] count;
    always_ff @(posedge MCLK) begin
        if (RESET || clr) count <= '0;
        else if (en && sec_tick) count <= count + 1'b1;
    end
    assign done = en && sec_tick && (count == limit - 1'b1);
endmodule

// File: rtl/alarm_controller.sv
// alarm_controller: alarm time store, match detect and ring/snooze FSM
module alarm_controller
    import clock_pkg::*;
#(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int MAX_SNOOZE     = 3,
    parameter int DEFAULT_HOUR   = 7,
    parameter int DEFAULT_MIN    = 0
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic              sec_tick,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic              set_en,
    input  logic [HOUR_W-1:0] set_hour,
    input  logic [MIN_W-1:0]  set_min,
    input  logic              arm_toggle,
    input  logic              dismiss,
    input  logic              snooze,
    output logic              alarm_ringing,
    output logic              alarm_armed,
    output logic [HOUR_W-1:0] alarm_hour,
    output logic [MIN_W-1:0]  alarm_min,
    output logic [1:0]        snooze_count
);
    localparam logic [CNT_W-1:0]  RING_LIM = CNT_W'(RING_TIMEOUT_S);
    localparam logic [CNT_W-1:0]  SNZ_LIM  = CNT_W'(SNOOZE_S);
    localparam logic [1:0]        SNZ_MAX  = 2'(MAX_SNOOZE);
    localparam logic [HOUR_W-1:0] DEF_HOUR = HOUR_W'(DEFAULT_HOUR);
    localparam logic [MIN_W-1:0]  DEF_MIN  = MIN_W'(DEFAULT_MIN);
    state_t     state, nxt;
    logic       match, match_q, trigger, set_ok, done, ring_d, armed_d;
    logic [1:0] sc_d;
    assign match   = (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == '0);
    assign trigger = match && !match_q;
    assign set_ok  = set_en && (set_hour <= MAX_HOUR) && (set_min <= MAX_MIN);
    alarm_sec_counter u_cnt (
        .MCLK     (MCLK),
        .RESET    (RESET),
        .clr      (nxt != state),
        .en       (state == ST_RINGING || state == ST_SNOOZE),
        .sec_tick (sec_tick),
        .limit    (state == ST_SNOOZE ? SNZ_LIM : RING_LIM),
        .done     (done)
    );
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state         <= ST_DISARMED;
            match_q       <= 1'b0;
            alarm_ringing <= 1'b0;
            alarm_armed   <= 1'b0;
            alarm_hour    <= DEF_HOUR;
            alarm_min     <= DEF_MIN;
            snooze_count  <= 2'd0;
        end else begin
            state         <= nxt;
            match_q       <= match;
            alarm_ringing <= ring_d;
            alarm_armed   <= armed_d;
            snooze_count  <= sc_d;
            if (set_ok) begin
                alarm_hour <= set_hour;
                alarm_min  <= set_min;
            end
        end
    end
    always_comb begin
        nxt = state;
        case (state)
            ST_DISARMED: nxt = arm_toggle ? ST_ARMED : ST_DISARMED;
            ST_ARMED:    nxt = arm_toggle ? ST_DISARMED : trigger ? ST_RINGING : ST_ARMED;
            ST_RINGING:  nxt = arm_toggle                         ? ST_DISARMED :
                               (dismiss || set_ok)                ? ST_ARMED    :
                               (snooze && snooze_count < SNZ_MAX) ? ST_SNOOZE   :
                               done                               ? ST_ARMED    : ST_RINGING;
            ST_SNOOZE:   nxt = arm_toggle          ? ST_DISARMED :
                               (dismiss || set_ok) ? ST_ARMED    :
                               done                ? ST_RINGING  : ST_SNOOZE;
            default:     nxt = ST_DISARMED;
        endcase
    end
    always_comb begin
        ring_d  = nxt == ST_RINGING;
        armed_d = nxt != ST_DISARMED;
        sc_d    = (nxt == ST_ARMED || nxt == ST_DISARMED)      ? 2'd0 :
                  (state == ST_RINGING && nxt == ST_SNOOZE)   ? snooze_count + 2'd1 : snooze_count;
    end
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: scoreboard bench with a countdown-based reference model
module tb_alarm_controller;
    localparam int RT = 60;
    localparam int SN = 300;
    localparam int MS = 3;

    typedef struct packed {
        logic       r;
        logic       a;
        logic [4:0] h;
        logic [5:0] m;
        logic [1:0] s;
    } exp_t;

    logic       MCLK = 0;
    logic       RESET = 0, sec_tick = 0, set_en = 0, arm_toggle = 0, dismiss = 0, snooze = 0;
    logic [4:0] cur_hour = 0, set_hour = 0;
    logic [5:0] cur_min = 0, cur_sec = 0, set_min = 0;
    logic       alarm_ringing, alarm_armed;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic [1:0] snooze_count;

    alarm_controller #(.RING_TIMEOUT_S(RT), .SNOOZE_S(SN), .MAX_SNOOZE(MS), .DEFAULT_HOUR(7), .DEFAULT_MIN(0)) dut (
        .MCLK(MCLK), .RESET(RESET), .sec_tick(sec_tick),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .set_en(set_en), .set_hour(set_hour), .set_min(set_min),
        .arm_toggle(arm_toggle), .dismiss(dismiss), .snooze(snooze),
        .alarm_ringing(alarm_ringing), .alarm_armed(alarm_armed),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min), .snooze_count(snooze_count)
    );

    always #5 MCLK = ~MCLK;

    exp_t q[$];
    int   vectors = 0, miscompares = 0;

    // pending stimulus for the next cycle
    logic       p_rst = 0, p_tk = 0, p_at = 0, p_dm = 0, p_sn = 0, p_se = 0;
    logic [4:0] p_sh = 0, ch = 0;
    logic [5:0] p_sm = 0, cm = 0, cs = 0;

    // reference model: 0=off 1=armed 2=ringing 3=snoozing, m_left counts seconds remaining
    int m_mode, m_left, m_snz, m_hr, m_mn;
    bit m_prev;

    function automatic void model_reset();
        m_mode = 0; m_left = 0; m_snz = 0; m_hr = 7; m_mn = 0; m_prev = 0;
    endfunction

    function automatic void model_step();
        bit match, trig, valid, expired;
        int old;
        match   = (ch == m_hr) && (cm == m_mn) && (cs == 0);
        trig    = match && !m_prev;
        m_prev  = match;
        valid   = p_se && p_sh <= 23 && p_sm <= 59;
        old     = m_mode;
        expired = (m_mode >= 2) && p_tk && (m_left == 1);
        if (m_mode >= 2 && p_tk) m_left--;
        if (m_mode == 0) begin
            if (p_at) m_mode = 1;
        end else if (m_mode == 1) begin
            if (p_at) m_mode = 0;
            else if (trig) m_mode = 2;
        end else if (m_mode == 2) begin
            if (p_at) m_mode = 0;
            else if (p_dm || valid) m_mode = 1;
            else if (p_sn && m_snz < MS) begin m_mode = 3; m_snz++; end
            else if (expired) m_mode = 1;
        end else begin
            if (p_at) m_mode = 0;
            else if (p_dm || valid) m_mode = 1;
            else if (expired) m_mode = 2;
        end
        if (m_mode < 2) m_snz = 0;
        if (m_mode != old) m_left = (m_mode == 2) ? RT : SN;
        if (valid) begin m_hr = p_sh; m_mn = p_sm; end
    endfunction

    task automatic cyc();
        exp_t e;
        @(negedge MCLK);
        RESET = p_rst; sec_tick = p_tk; arm_toggle = p_at; dismiss = p_dm; snooze = p_sn;
        set_en = p_se; set_hour = p_sh; set_min = p_sm;
        cur_hour = ch; cur_min = cm; cur_sec = cs;
        if (p_rst) model_reset();
        else model_step();
        e.r = (m_mode == 2); e.a = (m_mode != 0); e.h = 5'(m_hr); e.m = 6'(m_mn); e.s = 2'(m_snz);
        q.push_back(e);
        p_rst = 0; p_tk = 0; p_at = 0; p_dm = 0; p_sn = 0; p_se = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask
    task automatic ticks(input int n);
        repeat (n) begin p_tk = 1; cyc(); end
    endtask
    task automatic settime(input int h, input int m, input int s);
        ch = 5'(h); cm = 6'(m); cs = 6'(s);
    endtask
    task automatic set_alarm(input int h, input int m);
        p_se = 1; p_sh = 5'(h); p_sm = 6'(m); cyc();
    endtask
    task automatic ring_at(input int h, input int m);
        settime(h, m, 1); idle(2); settime(h, m, 0); idle(1);
    endtask

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge MCLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("alarm_ringing", int'(alarm_ringing), int'(e.r));
                check("alarm_armed",   int'(alarm_armed),   int'(e.a));
                check("alarm_hour",    int'(alarm_hour),    int'(e.h));
                check("alarm_min",     int'(alarm_min),     int'(e.m));
                check("snooze_count",  int'(snooze_count),  int'(e.s));
            end
        end
    end

    initial begin : stim
        int budget;
        model_reset();
        p_rst = 1; cyc(); p_rst = 1; cyc();
        idle(2);
        // arm, approach 07:00:00
        p_at = 1; cyc();
        settime(6, 59, 59); idle(3);
        settime(7, 0, 0); idle(2);
        // unattended ring times out; holding the match must not retrigger
        repeat (RT + 10) begin p_tk = 1; cyc(); cyc(); end
        // snooze cycle to saturation, 4th snooze ignored
        ring_at(7, 0);
        repeat (3) begin
            ticks(5); p_sn = 1; cyc(); idle(2); ticks(SN); idle(2);
        end
        p_sn = 1; cyc(); ticks(3);
        p_dm = 1; p_sn = 1; cyc(); idle(2);
        // arm_toggle beats dismiss
        ring_at(7, 0);
        p_at = 1; p_dm = 1; cyc(); idle(2);
        // invalid then valid set, trigger at 23:59
        set_alarm(24, 10); set_alarm(12, 60); idle(1);
        set_alarm(23, 59);
        p_at = 1; cyc();
        ring_at(23, 59);
        ticks(4); p_sn = 1; cyc(); ticks(10);
        set_alarm(7, 0); idle(2);
        // reset mid-ring at snooze_count=2
        ring_at(7, 0);
        repeat (2) begin p_sn = 1; cyc(); ticks(SN); end
        idle(2);
        p_rst = 1; cyc(); idle(1);
        ring_at(7, 0); idle(3);
        // randomized traffic around the current alarm time
        p_at = 1; cyc();
        repeat (4000) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: settime(m_hr, m_mn, 0);
                    1: settime(m_hr, m_mn, 1);
                    2: settime(m_hr, (m_mn + 59) % 60, 59);
                    default: settime($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
                endcase
            end
            p_tk = ($urandom_range(0, 1) == 0);
            p_at = ($urandom_range(0, 149) == 0);
            p_dm = ($urandom_range(0, 99) == 0);
            p_sn = ($urandom_range(0, 29) == 0);
            p_se = ($urandom_range(0, 299) == 0);
            p_sh = 5'($urandom_range(0, 31));
            p_sm = 6'($urandom_range(0, 63));
            p_rst = ($urandom_range(0, 1999) == 0);
            cyc();
        end
        idle(1);
        budget = 20;
        while (q.size() > 0 && budget > 0) begin @(posedge MCLK); budget--; end
        #2;
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
